// File: rtl/bcd_down_timer.sv
// Two-digit BCD countdown timer with start/pause/reload control.
// The count decrements on each tick strobe while running. At expiry the
// timer either stops (EXPIRED) or reloads and keeps going (AUTO_RELOAD=1).
// A registered one-cycle done pulse marks the cycle the count first shows
// 00, or the reload value when auto-reload is enabled.
module bcd_down_timer #(
    parameter logic [7:0] PRESET      = 8'h59,
    parameter bit         AUTO_RELOAD = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load_i,
    input  logic [7:0] load_val_i,
    input  logic       start_i,
    input  logic       pause_i,
    input  logic       tick_i,
    output logic [7:0] count_o,
    output logic       running_o,
    output logic       expired_o,
    output logic       done_o
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        PAUSE   = 2'd2,
        EXPIRED = 2'd3
    } state_t;

    // Limit each BCD nibble to 9 so the count always holds a legal BCD value.
    function automatic logic [7:0] clamp_bcd(input logic [7:0] v);
        logic [3:0] tens;
        logic [3:0] ones;
        tens = (v[7:4] > 4'd9) ? 4'd9 : v[7:4];
        ones = (v[3:0] > 4'd9) ? 4'd9 : v[3:0];
        return {tens, ones};
    endfunction

    // Subtract one in BCD, borrowing from the tens digit when ones is 0.
    // The caller never passes 00.
    function automatic logic [7:0] bcd_dec(input logic [7:0] v);
        logic [7:0] r;
        if (v[3:0] != 4'd0) begin
            r = {v[7:4], v[3:0] - 4'd1};
        end else begin
            r = {v[7:4] - 4'd1, 4'd9};
        end
        return r;
    endfunction

    localparam logic [7:0] PRESET_C = clamp_bcd(PRESET);

    state_t     state_q, state_d;
    logic [7:0] count_q, count_d;
    logic [7:0] reload_q, reload_d;
    logic       done_q, done_d;

    // Next-state logic. The if/else chain encodes the input priority
    // load > pause > start > tick. Reset is handled in the register process.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
        state_d  = state_q;
        count_d  = count_q;
        reload_d = reload_q;
        done_d   = 1'b0;

        if (load_i) begin
            count_d  = clamp_bcd(load_val_i);
            reload_d = clamp_bcd(load_val_i);
            state_d  = IDLE;
        end else if (pause_i && state_q == RUN) begin
            state_d = PAUSE;
        end else if (start_i && state_q != RUN) begin
            case (state_q)
                IDLE: begin
                    if (count_q != 8'h00) begin
                        state_d = RUN;
                    end
                end
                PAUSE: begin
                    state_d = RUN;
                end
                EXPIRED: begin
                    if (reload_q != 8'h00) begin
                        count_d = reload_q;
                        state_d = RUN;
                    end
                end
                default: begin
                end
            endcase
        end else if (tick_i && state_q == RUN && count_q != 8'h00) begin
            if (count_q == 8'h01) begin
                done_d = 1'b1;
                if (AUTO_RELOAD && reload_q != 8'h00) begin
                    count_d = reload_q;
                end else begin
                    count_d = 8'h00;
                    state_d = EXPIRED;
                end
            end else begin
                count_d = bcd_dec(count_q);
            end
        end
    end

    // State, count, reload and done registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state_q  <= IDLE;
            count_q  <= PRESET_C;
            reload_q <= PRESET_C;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            reload_q <= reload_d;
            done_q   <= done_d;
        end
    end

    assign count_o   = count_q;
    assign running_o = (state_q == RUN);
    assign expired_o = (state_q == EXPIRED);
    assign done_o    = done_q;

endmodule

// File: tb/tb_bcd_down_timer.sv
// Self-checking bench for bcd_down_timer. Two instances share the same
// stimulus: one stops at expiry and one auto-reloads. Directed scenarios
// come first, then randomized stimulus. Every cycle, both instances are
// compared against a decimal-integer reference model.
module tb_bcd_down_timer;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       load_i = 1'b0;
    logic [7:0] load_val_i = 8'h00;
    logic       start_i = 1'b0;
    logic       pause_i = 1'b0;
    logic       tick_i = 1'b0;

    logic [7:0] count0, count1;
    logic       running0, running1, expired0, expired1, done0, done1;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    bcd_down_timer #(.PRESET(8'h59), .AUTO_RELOAD(1'b0)) u_dut0 (
        .clk(clk), .rst(rst), .load_i(load_i), .load_val_i(load_val_i),
        .start_i(start_i), .pause_i(pause_i), .tick_i(tick_i),
        .count_o(count0), .running_o(running0), .expired_o(expired0), .done_o(done0)
    );

    bcd_down_timer #(.PRESET(8'h59), .AUTO_RELOAD(1'b1)) u_dut1 (
        .clk(clk), .rst(rst), .load_i(load_i), .load_val_i(load_val_i),
        .start_i(start_i), .pause_i(pause_i), .tick_i(tick_i),
        .count_o(count1), .running_o(running1), .expired_o(expired1), .done_o(done1)
    );

    // Reference model. The count is a plain decimal integer 0..99.
    typedef enum int {M_IDLE, M_RUN, M_PAUSE, M_EXP} mode_t;
    int    m_cnt [2];
    int    m_rel [2];
    mode_t m_mode[2];
    bit    m_done[2];

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Convert a BCD byte to decimal, limiting each digit to 9.
    function automatic int bcd_to_int(input logic [7:0] v);
        int t;
        int o;
        t = int'(v[7:4]);
        o = int'(v[3:0]);
        if (t > 9) t = 9;
        if (o > 9) o = 9;
        return t * 10 + o;
    endfunction

    function automatic logic [7:0] to_bcd(input int n);
        return 8'(((n / 10) << 4) | (n % 10));
    endfunction

    // Advance both model instances by one clock using the sampled inputs.
    task automatic model_step();
        for (int i = 0; i < 2; i++) begin
            m_done[i] = 1'b0;
            if (rst) begin
                m_cnt[i]  = 59;
                m_rel[i]  = 59;
                m_mode[i] = M_IDLE;
            end else if (load_i) begin
                m_cnt[i]  = bcd_to_int(load_val_i);
                m_rel[i]  = m_cnt[i];
                m_mode[i] = M_IDLE;
            end else if (pause_i && m_mode[i] == M_RUN) begin
                m_mode[i] = M_PAUSE;
            end else if (start_i && m_mode[i] != M_RUN) begin
                if (m_mode[i] == M_IDLE && m_cnt[i] != 0) m_mode[i] = M_RUN;
                else if (m_mode[i] == M_PAUSE) m_mode[i] = M_RUN;
                else if (m_mode[i] == M_EXP && m_rel[i] != 0) begin
                    m_cnt[i]  = m_rel[i];
                    m_mode[i] = M_RUN;
                end
            end else if (tick_i && m_mode[i] == M_RUN && m_cnt[i] > 0) begin
                m_cnt[i] = m_cnt[i] - 1;
                if (m_cnt[i] == 0) begin
                    m_done[i] = 1'b1;
                    if (i == 1 && m_rel[i] != 0) m_cnt[i] = m_rel[i];
                    else m_mode[i] = M_EXP;
                end
            end
        end
    endtask

    // One clock: update the model at the edge, then compare both instances.
    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        check("m0_count",   32'(count0),   32'(to_bcd(m_cnt[0])));
        check("m0_running", 32'(running0), 32'(m_mode[0] == M_RUN));
        check("m0_expired", 32'(expired0), 32'(m_mode[0] == M_EXP));
        check("m0_done",    32'(done0),    32'(m_done[0]));
        check("m1_count",   32'(count1),   32'(to_bcd(m_cnt[1])));
        check("m1_running", 32'(running1), 32'(m_mode[1] == M_RUN));
        check("m1_expired", 32'(expired1), 32'(m_mode[1] == M_EXP));
        check("m1_done",    32'(done1),    32'(m_done[1]));
    endtask

    task automatic drive(input bit r, input bit ld, input logic [7:0] lv,
                         input bit st, input bit ps, input bit tk);
        rst = r; load_i = ld; load_val_i = lv; start_i = st; pause_i = ps; tick_i = tk;
        cycle();
    endtask

    task automatic tick_n(input int n);
        for (int k = 0; k < n; k++) drive(0, 0, 8'h00, 0, 0, 1);
    endtask

    initial begin
        int dones;

        // Reset state and countdown from 12 to 00.
        drive(1, 0, 8'h00, 0, 0, 0);
        check("rst_count",   32'(count0),   32'h59);
        check("rst_running", 32'(running0), 32'd0);
        check("rst_expired", 32'(expired0), 32'd0);
        check("rst_done",    32'(done0),    32'd0);
        drive(0, 1, 8'h12, 0, 0, 0);
        check("ld12_count", 32'(count0), 32'h12);
        drive(0, 0, 8'h00, 1, 0, 0);
        check("start_running", 32'(running0), 32'd1);
        dones = 0;
        for (int k = 0; k < 12; k++) begin
            tick_n(1);
            check("cd_count", 32'(count0), 32'(to_bcd(11 - k)));
            dones += int'(done0);
            if (k == 11) check("cd_done_at_00", 32'(done0), 32'd1);
        end
        check("cd_done_count", 32'(dones), 32'd1);
        check("cd_expired",    32'(expired0), 32'd1);
        check("cd_not_run",    32'(running0), 32'd0);
        tick_n(2);
        check("cd_hold_00",    32'(count0), 32'h00);
        check("cd_no_redone",  32'(done0),  32'd0);

        // Borrow from tens, nibble clamping, and start ignored at 00.
        drive(0, 1, 8'h20, 0, 0, 0);
        drive(0, 0, 8'h00, 1, 0, 0);
        tick_n(1);
        check("borrow_19", 32'(count0), 32'h19);
        drive(0, 1, 8'hAF, 0, 0, 0);
        check("clamp_99", 32'(count0), 32'h99);
        drive(0, 1, 8'h00, 0, 0, 0);
        drive(0, 0, 8'h00, 1, 0, 0);
        check("zero_idle", 32'(running0), 32'd0);
        check("zero_cnt",  32'(count0),   32'h00);

        // Pause wins over a same-cycle tick; ticks are ignored while paused.
        drive(0, 1, 8'h09, 0, 0, 0);
        drive(0, 0, 8'h00, 1, 0, 0);
        tick_n(2);
        check("pre_pause_07", 32'(count0), 32'h07);
        drive(0, 0, 8'h00, 0, 1, 1);
        check("pause_cnt", 32'(count0),   32'h07);
        check("pause_run", 32'(running0), 32'd0);
        tick_n(3);
        check("paused_hold", 32'(count0), 32'h07);
        drive(0, 0, 8'h00, 1, 0, 0);
        check("resume_run", 32'(running0), 32'd1);
        tick_n(1);
        check("resume_06", 32'(count0), 32'h06);

        // Auto-reload instance: 03 -> 02 -> 01 -> 03 with done on the reload cycle.
        drive(0, 1, 8'h03, 0, 0, 0);
        drive(0, 0, 8'h00, 1, 0, 0);
        tick_n(1);
        check("ar_02", 32'(count1), 32'h02);
        check("ar_done_a", 32'(done1), 32'd0);
        tick_n(1);
        check("ar_01", 32'(count1), 32'h01);
        tick_n(1);
        check("ar_03",      32'(count1),   32'h03);
        check("ar_done_b",  32'(done1),    32'd1);
        check("ar_running", 32'(running1), 32'd1);
        tick_n(1);
        check("ar_done_c", 32'(done1), 32'd0);

        // Restart from EXPIRED reloads the last loaded value.
        drive(0, 1, 8'h05, 0, 0, 0);
        drive(0, 0, 8'h00, 1, 0, 0);
        tick_n(5);
        check("exp_state", 32'(expired0), 32'd1);
        drive(0, 0, 8'h00, 1, 0, 0);
        check("restart_cnt", 32'(count0),   32'h05);
        check("restart_run", 32'(running0), 32'd1);

        // Reset mid-run discards progress without a done pulse.
        drive(0, 1, 8'h34, 0, 0, 0);
        drive(0, 0, 8'h00, 1, 0, 0);
        drive(1, 0, 8'h00, 0, 0, 1);
        check("midrst_cnt",  32'(count0),   32'h59);
        check("midrst_run",  32'(running0), 32'd0);
        check("midrst_done", 32'(done0),    32'd0);

        // Randomized stimulus against the model.
        for (int n = 0; n < 3000; n++) begin
            logic [7:0] lv;
            lv = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 8'h15)) : 8'($urandom);
            drive(($urandom_range(0, 63) == 0), ($urandom_range(0, 15) == 0), lv,
                  ($urandom_range(0, 7) == 0), ($urandom_range(0, 15) == 0),
                  ($urandom_range(0, 1) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bcd_down_timer.md
BCD_DOWN_TIMER -- requirements
Module: bcd_down_timer

Interface
REQ-001 The block SHALL have parameter PRESET, default 8'h59, meaning the two-digit BCD count and reload value after reset.
REQ-002 The block SHALL have parameter AUTO_RELOAD, default 0, meaning: 1 = on expiry reload and keep running; 0 = stop at expiry.
REQ-003 clk  input  1  clock; all state changes on the rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 load  input  1  when high, capture load_val into count and the reload register.
REQ-006 load_val  input  8  BCD preset, [7:4] tens and [3:0] ones.
REQ-007 start  input  1  begin or resume counting.
REQ-008 pause  input  1  suspend counting.
REQ-009 tick  input  1  single-cycle count enable, e.g. 1 Hz strobe.
REQ-010 count  output  8  current BCD value, registered.
REQ-011 running  output  1  high while in RUN.
REQ-012 expired  output  1  high while in EXPIRED.
REQ-013 done  output  1  one-cycle pulse when the count reaches 00.

Function
REQ-014 The FSM SHALL have exactly four states: IDLE, RUN, PAUSE, EXPIRED.
REQ-015 Input priority per cycle SHALL be: rst > load > pause > start > tick.
REQ-016 On load in any state: count and reload SHALL take load_val, with each nibble >9 clamped to 9; state SHALL go to IDLE; done SHALL be 0.
REQ-017 On start in IDLE: the FSM SHALL go to RUN if count != 00, else the start is ignored.
REQ-018 On start in PAUSE: the FSM SHALL go to RUN with count unchanged.
REQ-019 On start in EXPIRED: count SHALL take reload and the FSM SHALL go to RUN, unless reload == 00, in which case the start is ignored.
REQ-020 On pause in RUN: the FSM SHALL go to PAUSE; a tick in the same cycle SHALL NOT decrement.
REQ-021 pause outside RUN SHALL have no effect.
REQ-022 tick SHALL decrement count only in RUN, and SHALL be ignored in all other states.
REQ-023 Decrement SHALL be BCD:
- ones != 0: ones-1.
- ones == 0: ones = 9 and tens-1.
- count 00 SHALL never be decremented.
REQ-024 A tick in RUN at count 01, with AUTO_RELOAD=0, SHALL set count to 00 and the state to EXPIRED on the same edge.
REQ-025 A tick in RUN at count 01, with AUTO_RELOAD=1, SHALL set count to reload and remain in RUN.
- If reload == 00, the FSM SHALL go to EXPIRED instead.
REQ-026 done SHALL be registered and asserted for exactly one cycle, in the cycle count first shows 00 (or shows the reload value, under auto-reload).
REQ-027 done SHALL never assert on load, pause, or start.
REQ-028 running and expired SHALL be decoded from registered state, never both high.
REQ-029 The per-tick latency from tick to updated count SHALL be one clock.

Reset
REQ-030 On rst, on the next edge, the block SHALL set:
- count and reload = PRESET, with nibbles >9 clamped;
- state = IDLE;
- running = expired = done = 0.
REQ-031 rst asserted mid-RUN or mid-PAUSE SHALL discard progress without emitting done.

Verification
REQ-032 Countdown: rst; load 8'h12; start; 12 ticks -> count 11,10,09,...,01,00; a single done with count 00; expired = 1; further ticks leave 00.
REQ-033 Borrow and clamp:
- load 8'h20, start, one tick -> count 8'h19.
- load 8'hAF -> count 8'h99.
- load 8'h00 then start -> stays IDLE.
REQ-034 Pause: at count 8'h07 in RUN, assert pause with tick -> count 07, running 0; 3 ticks -> 07; start, then tick -> 06.
REQ-035 Auto-reload (AUTO_RELOAD=1): load 8'h03, start, 3 ticks -> 02, 01, 03; done high on the 03 cycle only; running stays 1.
REQ-036 Restart and reset:
- In EXPIRED after load 8'h05, start -> count 05, RUN.
- rst at count 8'h34 in RUN -> count 8'h59, IDLE, done never pulsed.
